// File: rtl/moore_pkg.sv
// rtl/moore_pkg.sv - shared state encoding for the moore sequence generator/detector pair
package moore_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_SHIFT  = 3'd1;
    localparam logic [STATE_W-1:0] ST_PARITY = 3'd2;
    localparam logic [STATE_W-1:0] ST_GAP    = 3'd3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = ST_IDLE,
        S_SHIFT  = ST_SHIFT,
        S_PARITY = ST_PARITY,
        S_GAP    = ST_GAP
    } state_t;

endpackage

// File: rtl/moore_seq_shreg.sv
// rtl/moore_seq_shreg.sv - loadable shift register with direction select and enable
module moore_seq_shreg #(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             bit_out
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            if (load) begin
                q <= data;
            end else if (shift) begin
                if (LSB_FIRST) begin
                    q <= {1'b0, q[WIDTH-1:1]};
                end else begin
                    q <= {q[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    // The bit currently presented always sits at the exit end of the register.
    assign bit_out = LSB_FIRST ? q[0] : q[WIDTH-1];

endmodule

// File: rtl/moore_seq_gen.sv
// rtl/moore_seq_gen.sv - serial pattern transmitter; SEQ_GEN_PARITY_EN adds an even-parity bit
module moore_seq_gen
    import moore_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter bit LSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [WIDTH-1:0]   load_data,
    output logic               dout,
    output logic               dout_valid,
    output logic               done,
    output logic [STATE_W-1:0] state
);

    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PENULT    = CNT_W'(WIDTH - 2);
    localparam logic [7:0]       LAST_GAP  = 8'(GAP_CYCLES - 1);
    localparam state_t           POST_WORD = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] bit_cnt;
    logic [7:0]       gap_cnt;
    logic             done_d;
    logic             accept;
    logic             data_bit;

    assign load_ready = (state_q == S_IDLE);
    assign accept     = en && load_valid && load_ready;
    assign state      = state_q;

    moore_seq_shreg #(
        .WIDTH    (WIDTH),
        .LSB_FIRST(LSB_FIRST)
    ) u_shreg (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .load   (accept),
        .shift  (state_q == S_SHIFT),
        .data   (load_data),
        .bit_out(data_bit)
    );

`ifdef SEQ_GEN_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^load_data;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_valid) state_d = S_SHIFT;
            end
            S_SHIFT: begin
`ifdef SEQ_GEN_PARITY_EN
                done_d = (bit_cnt == LAST_BIT);
                if (bit_cnt == LAST_BIT) state_d = S_PARITY;
`else
                // done is registered, so it is raised one edge ahead of the last bit.
                done_d = (bit_cnt == PENULT);
                if (bit_cnt == LAST_BIT) state_d = POST_WORD;
`endif
            end
`ifdef SEQ_GEN_PARITY_EN
            S_PARITY: state_d = POST_WORD;
`endif
            S_GAP: begin
                if (gap_cnt == LAST_GAP) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
            done    <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            done    <= done_d;
            bit_cnt <= (state_q == S_SHIFT) ? bit_cnt + CNT_W'(1) : '0;
            gap_cnt <= (state_q == S_GAP) ? gap_cnt + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        dout       = 1'b0;
        dout_valid = 1'b0;
        case (state_q)
            S_SHIFT: begin
                dout       = data_bit;
                dout_valid = 1'b1;
            end
`ifdef SEQ_GEN_PARITY_EN
            S_PARITY: begin
                dout       = par_q;
                dout_valid = 1'b1;
            end
`endif
            default: begin
                dout       = 1'b0;
                dout_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_moore_seq_gen.sv
// tb/tb_moore_seq_gen.sv - randomized self-checking bench for moore_seq_gen against a word-level model
module tb_moore_seq_gen;
    import moore_pkg::*;

    localparam int W  = 16;
    localparam int NI = 3;
`ifdef SEQ_GEN_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic [NI-1:0]       en;
    logic [NI-1:0]       load_valid;
    logic [NI-1:0]       load_ready;
    logic [NI-1:0]       dout;
    logic [NI-1:0]       dout_valid;
    logic [NI-1:0]       done;
    logic [W-1:0]        load_data [NI];
    logic [STATE_W-1:0]  state     [NI];

    int vectors = 0;
    int errors  = 0;

    // Instance 0: nominal, 1: three-cycle gap, 2: MSB first.
    moore_seq_gen #(.WIDTH(W), .LSB_FIRST(1'b1), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .en(en[0]), .load_valid(load_valid[0]),
        .load_ready(load_ready[0]), .load_data(load_data[0]), .dout(dout[0]),
        .dout_valid(dout_valid[0]), .done(done[0]), .state(state[0]));
    moore_seq_gen #(.WIDTH(W), .LSB_FIRST(1'b1), .GAP_CYCLES(3)) dut1 (
        .clk(clk), .reset(reset), .en(en[1]), .load_valid(load_valid[1]),
        .load_ready(load_ready[1]), .load_data(load_data[1]), .dout(dout[1]),
        .dout_valid(dout_valid[1]), .done(done[1]), .state(state[1]));
    moore_seq_gen #(.WIDTH(W), .LSB_FIRST(1'b0), .GAP_CYCLES(0)) dut2 (
        .clk(clk), .reset(reset), .en(en[2]), .load_valid(load_valid[2]),
        .load_ready(load_ready[2]), .load_data(load_data[2]), .dout(dout[2]),
        .dout_valid(dout_valid[2]), .done(done[2]), .state(state[2]));

    function automatic bit lsb_of(input int k);
        return (k != 2);
    endfunction

    function automatic int gap_of(input int k);
        return (k == 1) ? 3 : 0;
    endfunction

    // en_mode: 0 = always enabled, 1 = alternate 0/1, 2 = random.
    task automatic send(input int k, input logic [W-1:0] word, input int en_mode, input bit busy_pulse);
        bit   ev[$];
        bit   ed[$];
        bit   edn[$];
        bit   er[$];
        int   cyc;
        int   seen;
        int   pulse_at;
        bit   last_en;
        logic [3:0] exp_t;
        logic [3:0] got_t;
        logic [6:0] prev;
        logic [6:0] now;

        for (int i = 0; i < W; i++) begin
            ev.push_back(1'b1);
            ed.push_back(lsb_of(k) ? word[i] : word[W-1-i]);
            edn.push_back(PAR == 0 && i == W - 1);
            er.push_back(1'b0);
        end
        if (PAR == 1) begin
            ev.push_back(1'b1);
            ed.push_back(bit'($countones(word) % 2));
            edn.push_back(1'b1);
            er.push_back(1'b0);
        end
        for (int i = 0; i < gap_of(k); i++) begin
            ev.push_back(1'b0); ed.push_back(1'b0); edn.push_back(1'b0); er.push_back(1'b0);
        end
        ev.push_back(1'b0); ed.push_back(1'b0); edn.push_back(1'b0); er.push_back(1'b1);

        @(negedge clk);
        cyc = 0;
        while (load_ready[k] !== 1'b1 && cyc < 100) begin
            en[k] = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 100) begin
            vectors++; errors++;
            $display("FAIL ready_timeout dut%0d: load_ready=%b required 1", k, load_ready[k]);
            return;
        end

        en[k] = 1'b1; load_valid[k] = 1'b1; load_data[k] = word;
        @(negedge clk);
        load_valid[k] = 1'b0; load_data[k] = W'($urandom);
        last_en  = 1'b1;
        seen     = 0;
        cyc      = 0;
        pulse_at = $urandom_range(2, W - 4);
        prev     = '0;
        while (seen < ev.size() && cyc < 400) begin
            now = {dout_valid[k], dout[k], done[k], load_ready[k], state[k]};
            vectors++;
            if (last_en) begin
                exp_t = {ev[seen], ed[seen], edn[seen], er[seen]};
                got_t = now[6:3];
                if (got_t !== exp_t) begin
                    errors++;
                    $display("FAIL stream dut%0d word=%h idx=%0d {valid,dout,done,ready}=%b required %b",
                             k, word, seen, got_t, exp_t);
                end
                seen++;
            end else if (now !== prev) begin
                errors++;
                $display("FAIL hold dut%0d word=%h idx=%0d outputs=%b required %b (en=0)",
                         k, word, seen, now, prev);
            end
            prev = now;
            case (en_mode)
                0:       en[k] = 1'b1;
                1:       en[k] = cyc[0];
                default: en[k] = 1'($urandom_range(0, 1));
            endcase
            load_valid[k] = busy_pulse && (cyc == pulse_at);
            load_data[k]  = W'($urandom);
            last_en = en[k];
            cyc++;
            @(negedge clk);
        end
        load_valid[k] = 1'b0;
        en[k] = 1'b1;
        if (seen < ev.size()) begin
            vectors++; errors++;
            $display("FAIL word_timeout dut%0d: %0d enabled samples seen required %0d", k, seen, ev.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < NI; k++) begin
            vectors++;
            if ({dout_valid[k], dout[k], done[k], load_ready[k], state[k]} !== {4'b0001, ST_IDLE}) begin
                errors++;
                $display("FAIL %s dut%0d {valid,dout,done,ready,state}=%b required %b",
                         tag, k, {dout_valid[k], dout[k], done[k], load_ready[k], state[k]},
                         {4'b0001, ST_IDLE});
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        en = '1; load_valid = '0;
        for (int k = 0; k < NI; k++) load_data[k] = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        reset = 1'b1;
    endtask

    task automatic test_nominal();
        send(0, 16'b1101101101101101, 0, 1'b0);
    endtask

    task automatic test_enable_pacing();
        send(0, 16'b1101101101101101, 1, 1'b0);
        for (int i = 0; i < 2; i++) send(0, W'($urandom), 2, 1'b0);
    endtask

    task automatic test_gap_busy();
        for (int i = 0; i < 3; i++) send(1, W'($urandom), 0, 1'b1);
        send(0, W'($urandom), 0, 1'b1);
    endtask

    task automatic test_msb_first();
        send(2, 16'h8001, 0, 1'b0);
        send(2, W'($urandom), 2, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            int k;
            k = $urandom_range(0, NI - 1);
            send(k, W'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_word();
        @(negedge clk);
        en[0] = 1'b1; load_valid[0] = 1'b1; load_data[0] = 16'hA5C3;
        @(negedge clk);
        load_valid[0] = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_outputs("reset_mid_word");
        @(negedge clk);
        reset = 1'b1;
        send(0, 16'h3C5A, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_enable_pacing();
        test_gap_busy();
        test_msb_first();
        test_back_to_back();
        test_reset_mid_word();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
